// File: rtl/id_exe_pipe_stage_if.sv
// ID->EXE stage bus: upstream valid/ready + payload, downstream valid/ready + payload.
interface id_exe_pipe_stage_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned REG_AW   = 5
);
    // Upstream (ID) side
    logic                in_valid;
    logic                in_ready;
    logic                RegDst_in;
    logic [ALU_OP_W-1:0] ALUOp_in;
    logic                Write_reg_mux_in;
    logic                Memwrite_in;
    logic                ALUsrc_in;
    logic                RegWrite_in;
    logic [DATA_W-1:0]   Read_data_1_in;
    logic [DATA_W-1:0]   Read_data_2_in;
    logic [DATA_W-1:0]   imm_ext_in;
    logic [REG_AW-1:0]   rt_in;
    logic [REG_AW-1:0]   rd_in;

    // Downstream (EXE) side
    logic                out_valid;
    logic                out_ready;
    logic                RegDst_out;
    logic [ALU_OP_W-1:0] ALUOp_out;
    logic                Write_reg_mux_out;
    logic                Memwrite_out;
    logic                ALUsrc_out;
    logic                RegWrite_out;
    logic [DATA_W-1:0]   Read_data_1_out;
    logic [DATA_W-1:0]   Read_data_2_out;
    logic [DATA_W-1:0]   imm_ext_out;
    logic [REG_AW-1:0]   rt_out;
    logic [REG_AW-1:0]   rd_out;

    // Environment view: drives instructions in, consumes them out
    modport master (
        output in_valid, RegDst_in, ALUOp_in, Write_reg_mux_in, Memwrite_in,
               ALUsrc_in, RegWrite_in, Read_data_1_in, Read_data_2_in,
               imm_ext_in, rt_in, rd_in, out_ready,
        input  in_ready, out_valid, RegDst_out, ALUOp_out, Write_reg_mux_out,
               Memwrite_out, ALUsrc_out, RegWrite_out, Read_data_1_out,
               Read_data_2_out, imm_ext_out, rt_out, rd_out
    );

    // Pipeline stage view
    modport slave (
        input  in_valid, RegDst_in, ALUOp_in, Write_reg_mux_in, Memwrite_in,
               ALUsrc_in, RegWrite_in, Read_data_1_in, Read_data_2_in,
               imm_ext_in, rt_in, rd_in, out_ready,
        output in_ready, out_valid, RegDst_out, ALUOp_out, Write_reg_mux_out,
               Memwrite_out, ALUsrc_out, RegWrite_out, Read_data_1_out,
               Read_data_2_out, imm_ext_out, rt_out, rd_out
    );
endinterface

// File: rtl/id_exe_pipe_stage.sv
// ID->EXE pipeline stage with valid/ready handshake, 1-entry skid buffer,
// registered in_ready, flush, bubble masking and a saturating stall counter.
module id_exe_pipe_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ALU_OP_W = 2,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned STALL_CW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    id_exe_pipe_stage_if.slave   bus,
    output logic [STALL_CW-1:0]  stall_cnt
);

    localparam logic [STALL_CW-1:0] STALL_MAX = '1;

    typedef struct packed {
        logic                reg_dst;
        logic [ALU_OP_W-1:0] alu_op;
        logic                write_reg_mux;
        logic                mem_write;
        logic                alu_src;
        logic                reg_write;
    } ctrl_t;

    typedef struct packed {
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic [DATA_W-1:0] imm;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } data_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q;
    logic                  out_valid_q;
    ctrl_t                 main_ctrl_q, skid_ctrl_q;
    data_t                 main_data_q, skid_data_q;
    logic [STALL_CW-1:0]   stall_cnt_q;

    ctrl_t                 in_ctrl_c;
    data_t                 in_data_c;
    logic                  acc_c;
    logic                  deq_c;
    logic                  ld_main_in_c;
    logic                  ld_main_skid_c;
    logic                  ld_skid_c;

    // Gather the incoming payload into struct form
    assign in_ctrl_c = '{reg_dst:       bus.RegDst_in,
                         alu_op:        bus.ALUOp_in,
                         write_reg_mux: bus.Write_reg_mux_in,
                         mem_write:     bus.Memwrite_in,
                         alu_src:       bus.ALUsrc_in,
                         reg_write:     bus.RegWrite_in};
    assign in_data_c = '{rd1: bus.Read_data_1_in,
                         rd2: bus.Read_data_2_in,
                         imm: bus.imm_ext_in,
                         rt:  bus.rt_in,
                         rd:  bus.rd_in};

    assign acc_c = bus.in_valid & in_ready_q;
    assign deq_c = out_valid_q & bus.out_ready;

    // Next-state and entry-load decisions; flush overrides everything
    always_comb begin
        state_d        = state_q;
        ld_main_in_c   = 1'b0;
        ld_main_skid_c = 1'b0;
        ld_skid_c      = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc_c) begin
                        ld_main_in_c = 1'b1;
                        state_d      = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc_c && deq_c) begin
                        ld_main_in_c = 1'b1;
                    end else if (acc_c) begin
                        ld_skid_c = 1'b1;
                        state_d   = ST_TWO;
                    end else if (deq_c) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (deq_c) begin
                        ld_main_skid_c = 1'b1;
                        state_d        = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State register plus registered handshake flags derived from next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // MAIN control fields: forced to zero whenever the stage goes empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_ctrl_q <= '0;
        end else if (ld_main_in_c) begin
            main_ctrl_q <= in_ctrl_c;
        end else if (ld_main_skid_c) begin
            main_ctrl_q <= skid_ctrl_q;
        end else if (state_d == ST_EMPTY) begin
            main_ctrl_q <= '0;
        end
    end

    // MAIN data fields: only change on a load, so bubbles never toggle them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data_q <= '0;
        end else if (ld_main_in_c) begin
            main_data_q <= in_data_c;
        end else if (ld_main_skid_c) begin
            main_data_q <= skid_data_q;
        end
    end

    // SKID entry captures the accepted instruction while MAIN is stalled
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else if (ld_skid_c) begin
            skid_ctrl_q <= in_ctrl_c;
            skid_data_q <= in_data_c;
        end
    end

    // Saturating count of stalled cycles, cleared on dequeue or flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (flush || deq_c) begin
            stall_cnt_q <= '0;
        end else if (out_valid_q && !bus.out_ready && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_q <= stall_cnt_q + STALL_CW'(1);
        end
    end

    // Drive registered state onto the bus
    assign bus.in_ready          = in_ready_q;
    assign bus.out_valid         = out_valid_q;
    assign bus.RegDst_out        = main_ctrl_q.reg_dst;
    assign bus.ALUOp_out         = main_ctrl_q.alu_op;
    assign bus.Write_reg_mux_out = main_ctrl_q.write_reg_mux;
    assign bus.Memwrite_out      = main_ctrl_q.mem_write;
    assign bus.ALUsrc_out        = main_ctrl_q.alu_src;
    assign bus.RegWrite_out      = main_ctrl_q.reg_write;
    assign bus.Read_data_1_out   = main_data_q.rd1;
    assign bus.Read_data_2_out   = main_data_q.rd2;
    assign bus.imm_ext_out       = main_data_q.imm;
    assign bus.rt_out            = main_data_q.rt;
    assign bus.rd_out            = main_data_q.rd;
    assign stall_cnt             = stall_cnt_q;

endmodule

// File: tb/tb_id_exe_pipe_stage.sv
// Self-checking bench for id_exe_pipe_stage: scenario tasks plus a payload scoreboard.
module tb_id_exe_pipe_stage;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ALU_OP_W = 2;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned STALL_CW = 4;

    logic                clk   = 1'b0;
    logic                rst   = 1'b0;
    logic                flush = 1'b0;
    logic [STALL_CW-1:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    id_exe_pipe_stage_if #(.DATA_W(DATA_W), .ALU_OP_W(ALU_OP_W), .REG_AW(REG_AW)) bus ();

    id_exe_pipe_stage #(
        .DATA_W  (DATA_W),
        .ALU_OP_W(ALU_OP_W),
        .REG_AW  (REG_AW),
        .STALL_CW(STALL_CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               reg_dst;
        logic [1:0]         alu_op;
        logic               wrm;
        logic               mw;
        logic               asrc;
        logic               rw;
        logic [31:0]        rd1;
        logic [31:0]        rd2;
        logic [31:0]        imm;
        logic [4:0]         rt;
        logic [4:0]         rd;
    } pl_t;

    pl_t sb[$];

    function automatic pl_t make_pl(input int i);
        pl_t p;
        p.reg_dst = i[0];
        p.alu_op  = 2'(i >> 1);
        p.wrm     = i[3];
        p.mw      = i[4];
        p.asrc    = i[5];
        p.rw      = ~i[0];
        p.rd1     = 32'(i);
        p.rd2     = 32'(i * 7 + 3);
        p.imm     = 32'h A5A5_0000 ^ 32'(i);
        p.rt      = 5'(i + 1);
        p.rd      = 5'(i + 2);
        return p;
    endfunction

    function automatic pl_t in_pl();
        pl_t p;
        p = '{bus.RegDst_in, bus.ALUOp_in, bus.Write_reg_mux_in, bus.Memwrite_in,
              bus.ALUsrc_in, bus.RegWrite_in, bus.Read_data_1_in, bus.Read_data_2_in,
              bus.imm_ext_in, bus.rt_in, bus.rd_in};
        return p;
    endfunction

    function automatic pl_t out_pl();
        pl_t p;
        p = '{bus.RegDst_out, bus.ALUOp_out, bus.Write_reg_mux_out, bus.Memwrite_out,
              bus.ALUsrc_out, bus.RegWrite_out, bus.Read_data_1_out, bus.Read_data_2_out,
              bus.imm_ext_out, bus.rt_out, bus.rd_out};
        return p;
    endfunction

    task automatic drive(input pl_t p, input logic v);
        bus.in_valid         = v;
        bus.RegDst_in        = p.reg_dst;
        bus.ALUOp_in         = p.alu_op;
        bus.Write_reg_mux_in = p.wrm;
        bus.Memwrite_in      = p.mw;
        bus.ALUsrc_in        = p.asrc;
        bus.RegWrite_in      = p.rw;
        bus.Read_data_1_in   = p.rd1;
        bus.Read_data_2_in   = p.rd2;
        bus.imm_ext_in       = p.imm;
        bus.rt_in            = p.rt;
        bus.rd_in            = p.rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: values sampled mid-cycle are what the next edge acts on
    always @(negedge clk) begin : mon
        pl_t exp_p;
        pl_t got_p;
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow: got rd1=%0d with nothing expected", bus.Read_data_1_out);
                end else begin
                    exp_p = sb.pop_front();
                    got_p = out_pl();
                    if (got_p !== exp_p) begin
                        bad++;
                        $display("FAIL sb_payload: got %h expected %h", got_p, exp_p);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(in_pl());
            if (!bus.out_valid) begin
                total++;
                if ({bus.RegDst_out, bus.ALUOp_out, bus.Write_reg_mux_out, bus.Memwrite_out,
                     bus.ALUsrc_out, bus.RegWrite_out} !== 7'b0) begin
                    bad++;
                    $display("FAIL bubble_ctrl: got ctrl=%b expected 0",
                             {bus.RegDst_out, bus.ALUOp_out, bus.Write_reg_mux_out,
                              bus.Memwrite_out, bus.ALUsrc_out, bus.RegWrite_out});
                end
            end
        end
    end

    task automatic test_reset();
        #12;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
        total++; if (bus.RegWrite_out !== 1'b0) begin bad++; $display("FAIL rst_regwrite: got %b expected 0", bus.RegWrite_out); end
        total++; if (bus.Read_data_1_out !== 32'd0) begin bad++; $display("FAIL rst_rd1: got %0d expected 0", bus.Read_data_1_out); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(make_pl(i), 1'b1);
            step();
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            total++; if (bus.Read_data_1_out !== 32'(i)) begin bad++; $display("FAIL stream_rd1[%0d]: got %0d expected %0d", i, bus.Read_data_1_out, i); end
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
        end
        drive(make_pl(0), 1'b0);
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(make_pl(100), 1'b1);
        step();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_a: got %b expected 1", bus.in_ready); end
        drive(make_pl(101), 1'b1);
        step();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_b: got %b expected 0", bus.in_ready); end
        drive(make_pl(102), 1'b1);
        step();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_c: got %b expected 0", bus.in_ready); end
        total++; if (bus.Read_data_1_out !== 32'd100) begin bad++; $display("FAIL bp_head: got %0d expected 100", bus.Read_data_1_out); end
        total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL bp_stall: got %0d expected 2", stall_cnt); end
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.Read_data_1_out !== 32'd101) begin bad++; $display("FAIL bp_second: got %0d expected 101", bus.Read_data_1_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_reopen: got %b expected 1", bus.in_ready); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL bp_stall_clr: got %0d expected 0", stall_cnt); end
        step();
        total++; if (bus.Read_data_1_out !== 32'd102) begin bad++; $display("FAIL bp_third: got %0d expected 102", bus.Read_data_1_out); end
        drive(make_pl(0), 1'b0);
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        pl_t p;
        bus.out_ready = 1'b0;
        p = make_pl(200); p.rw = 1'b1; p.mw = 1'b1;
        drive(p, 1'b1);
        step();
        p = make_pl(201); p.rw = 1'b1; p.mw = 1'b1;
        drive(p, 1'b1);
        step();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL fl_two: got in_ready %b expected 0", bus.in_ready); end
        drive(make_pl(202), 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid: got %b expected 0", bus.out_valid); end
        total++; if (bus.RegWrite_out !== 1'b0) begin bad++; $display("FAIL fl_regwrite: got %b expected 0", bus.RegWrite_out); end
        total++; if (bus.Memwrite_out !== 1'b0) begin bad++; $display("FAIL fl_memwrite: got %b expected 0", bus.Memwrite_out); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL fl_ready: got %b expected 1", bus.in_ready); end
        total++; if (bus.Read_data_1_out !== 32'd200) begin bad++; $display("FAIL fl_hold: got %0d expected 200", bus.Read_data_1_out); end
        drive(make_pl(202), 1'b0);
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fl_no_capture_two: got %b expected 0", bus.out_valid); end
        drive(make_pl(203), 1'b1);
        step();
        p = make_pl(204); p.rw = 1'b1;
        drive(p, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(p, 1'b0);
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fl_no_capture_one: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_stall_sat();
        bus.out_ready = 1'b0;
        drive(make_pl(300), 1'b1);
        step();
        drive(make_pl(300), 1'b0);
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL st_start: got %0d expected 0", stall_cnt); end
        for (int n = 1; n <= 20; n++) begin
            step();
            if (n == 14) begin
                total++; if (stall_cnt !== 4'd14) begin bad++; $display("FAIL st_14: got %0d expected 14", stall_cnt); end
            end
        end
        total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL st_sat: got %0d expected 15", stall_cnt); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL st_valid: got %b expected 1", bus.out_valid); end
        bus.out_ready = 1'b1;
        step();
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL st_clear: got %0d expected 0", stall_cnt); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL st_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_bubble();
        pl_t p;
        bus.out_ready = 1'b1;
        p = make_pl(400);
        p.rw = 1'b1; p.mw = 1'b1; p.reg_dst = 1'b1; p.wrm = 1'b1; p.asrc = 1'b1; p.alu_op = 2'b11;
        drive(p, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (bus.RegWrite_out !== 1'b0) begin bad++; $display("FAIL bub_regwrite[%0d]: got %b expected 0", k, bus.RegWrite_out); end
            total++; if (bus.ALUOp_out !== 2'b00) begin bad++; $display("FAIL bub_aluop[%0d]: got %b expected 0", k, bus.ALUOp_out); end
            total++; if (bus.Read_data_1_out !== 32'd300) begin bad++; $display("FAIL bub_hold[%0d]: got %0d expected 300", k, bus.Read_data_1_out); end
        end
    endtask

    task automatic test_reset_midstream();
        bus.out_ready = 1'b0;
        drive(make_pl(500), 1'b1);
        step();
        drive(make_pl(501), 1'b1);
        step();
        drive(make_pl(502), 1'b1);
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mr_two: got in_ready %b expected 0", bus.in_ready); end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mr_valid: got %b expected 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mr_ready: got %b expected 1", bus.in_ready); end
        total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL mr_stall: got %0d expected 0", stall_cnt); end
        total++; if (bus.Read_data_1_out !== 32'd0) begin bad++; $display("FAIL mr_rd1: got %0d expected 0", bus.Read_data_1_out); end
        total++; if (bus.RegWrite_out !== 1'b0) begin bad++; $display("FAIL mr_regwrite: got %b expected 0", bus.RegWrite_out); end
        drive(make_pl(0), 1'b0);
        step();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mr_after: got %b expected 0", bus.out_valid); end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        drive(make_pl(0), 1'b0);
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_stall_sat();
        test_bubble();
        test_reset_midstream();
        step();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
